// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered long-latency
// results onto one register-file write port, and tracks pending destinations.
module writeback_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          alu_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      alu_rd_i,
   input  logic [DATA_WIDTH-1:0]         alu_data_i,
   input  logic                          lsu_valid_i,
   output logic                          lsu_ready_o,
   input  logic [ADDRESS_WIDTH-1:0]      lsu_rd_i,
   input  logic [DATA_WIDTH-1:0]         lsu_data_i,
   input  logic                          issue_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      issue_rd_i,
   output logic [2**ADDRESS_WIDTH-1:0]   pending_o,
   output logic                          alu_stall_o,
   output logic                          rf_we_o,
   output logic [ADDRESS_WIDTH-1:0]      rf_addr_o,
   output logic [DATA_WIDTH-1:0]         rf_wd_o
);

   localparam int NUM_REGS = 2**ADDRESS_WIDTH;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STV_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   logic [ADDRESS_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_wd_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [STV_W-1:0]         starve_q, starve_d;
   logic                     stall_q, stall_d;
   logic [NUM_REGS-1:0]      pending_q, pending_d;
   logic [NUM_REGS-1:0]      set_vec, clr_vec;
   logic                     rf_we_q, rf_we_d;
   logic [ADDRESS_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0]    rf_wd_q, rf_wd_d;

   logic fifo_empty, push, pop, alu_live;

   // Valid/ready: an LSU transfer happens on any cycle where lsu_valid_i and
   // lsu_ready_o are both high; ready depends only on registered occupancy.
   assign fifo_empty  = (count_q == '0);
   assign lsu_ready_o = (count_q != DEPTH_C);
   assign push        = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
   assign alu_live    = alu_valid_i && (alu_rd_i != '0) && !stall_q;
   // While stalled alu_live is low, so a stall cycle always drains the head.
   assign pop         = !fifo_empty && !alu_live;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_comb begin
      stall_d  = 1'b0;
      starve_d = '0;
      if (!fifo_empty && alu_live) begin
         if ((starve_q + 1'b1) == LIMIT_C) stall_d = 1'b1;
         else                              starve_d = starve_q + 1'b1;
      end
   end

   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_wd_d   = rf_wd_q;
      if (pop) begin
         rf_we_d   = 1'b1;
         rf_addr_d = fifo_rd_q[rd_ptr_q];
         rf_wd_d   = fifo_wd_q[rd_ptr_q];
      end else if (alu_live) begin
         rf_we_d   = 1'b1;
         rf_addr_d = alu_rd_i;
         rf_wd_d   = alu_data_i;
      end
   end

   // A newly issued destination wins over a same-edge clear of that register.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (pop) clr_vec[fifo_rd_q[rd_ptr_q]] = 1'b1;
      if (issue_valid_i && (issue_rd_i != '0)) set_vec[issue_rd_i] = 1'b1;
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q] <= lsu_rd_i;
         fifo_wd_q[wr_ptr_q] <= lsu_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
         pending_q <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_wd_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         pending_q <= pending_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_wd_q   <= rf_wd_d;
      end
   end

   assign pending_o   = pending_q;
   assign alu_stall_o = stall_q;
   assign rf_we_o     = rf_we_q;
   assign rf_addr_o   = rf_addr_q;
   assign rf_wd_o     = rf_wd_q;

endmodule
